pwm_fade_ctrl: RTL
==================

// Module: pwm_fade_ctrl
// PURPOSE
//   Duty-cycle sequencer for the PWM LED core. Debounces the push switch and runs an
//   OFF/RISE/ON/FALL fade state machine. Presents a new duty value to the PWM core only
//   at a PWM period boundary, so no period is ever glitched. Sits between sw_in and the
//   PWM core's duty input inside pwm_top.
// PARAMETERS
//   SYS_CLOCK_FREQ  50_000_000  clk frequency in Hz
//   SCALE           256         PWM steps per period; duty range is 0..SCALE-1
//   DIV             1024        clk cycles per duty step while fading
//   DEB_MS          20          debounce window in ms; DEB_CYC = SYS_CLOCK_FREQ/1000*DEB_MS
// PORTS
//   clk         in   1            system clock
//   rst         in   1            synchronous reset, active-high
//   sw_in       in   1            raw switch, active-low (idle 1), asynchronous
//   period_end  in   1            1-cycle pulse from the PWM core at counter wrap
//   duty        out  W=$clog2(SCALE)  duty register driving the PWM core
//   duty_load   out  1            1-cycle pulse in the same cycle duty changes
//   state       out  2            00 OFF, 01 RISE, 10 ON, 11 FALL
//   busy        out  1            1 while state is RISE or FALL
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): state=OFF, duty=0, duty_load=0, busy=0, internal
//     target=0, prescaler=0, debounce counter=0. Synchronizer FFs and the debounced level
//     reset to 1 (released).
//   - Input path: 2-FF synchronizer, then debouncer. A level change is accepted after
//     DEB_CYC consecutive equal synchronized samples. Any bounce restarts the count.
//   - press: 1-cycle pulse on an accepted 1->0 transition. Release generates nothing.
//     Press latency is 2 + DEB_CYC clocks after sw_in falls.
//   - Prescaler: counts 0..DIV-1 only in RISE/FALL; tick = (cnt==DIV-1). It is held at 0
//     in OFF/ON and cleared on every state change.
//   - FSM (transition on press or tick; press has priority; a tick in the same cycle as
//     a press is discarded):
//       OFF  --press--> RISE
//       RISE --press--> FALL (reverses from the current target)
//       RISE --tick, target==SCALE-2--> ON (target becomes SCALE-1)
//       RISE --tick--> target+1
//       ON   --press--> FALL
//       FALL --press--> RISE
//       FALL --tick, target==1--> OFF (target becomes 0)
//       FALL --tick--> target-1
//   - target saturates: never below 0, never above SCALE-1; no wrap-around.
//   - A full ramp takes (SCALE-1)*DIV clocks.
//   - Duty handshake: on period_end, if target != duty then duty <= target and
//     duty_load=1 in that cycle. If target == duty, no load occurs.
//   - duty is never updated except on period_end. Intermediate targets between two
//     period_end pulses are skipped; only the latest target is loaded.
//   - period_end coinciding with a target update: duty takes the pre-update target; the
//     new target is loaded at the next period_end.
//   - state and busy are registered and reflect the current FSM state.
//   - rst mid-fade: everything returns to reset values on the next clk edge; duty drops
//     to 0 immediately (reset overrides the boundary rule).
// STRUCTURE
//   - Package pwm_pkg: state encoding localparams (ST_OFF, ST_RISE, ST_ON, ST_FALL) and
//     the duty-width function shared with the PWM core.
//   - Sub-module sw_debounce (params SYS_CLOCK_FREQ, DEB_MS): synchronizer, debounce
//     counter and press pulse generator.
//   - FSM, prescaler and duty handshake stay in this module.
// TESTING  (SYS_CLOCK_FREQ=1000, DEB_MS=3 -> DEB_CYC=3; SCALE=8; DIV=4; period_end every 8 clk)
//   1. Reset: hold rst 3 cycles, sw_in=1 -> state=00, duty=0, duty_load=0, busy=0.
//   2. Bounce: sw_in low 2 clk, high 1, low 2, then high -> no press; state stays OFF.
//   3. Full rise: sw_in low 10 clk -> RISE 5 clk after the fall. Target steps 1..7 every
//      4 clk. state=ON after 28 clk. duty reaches 7 at the first period_end afterwards.
//      duty changes only in period_end cycles, each with duty_load=1.
//   4. Reversal: press while RISE with target=3 -> state=FALL, prescaler=0. Target is 2
//      four clk later and 0 at +12 clk; then state=OFF, busy=0.
//   5. Simultaneous events: press in the same cycle as a tick -> direction changes and the
//      target does not step. period_end in the same cycle as a target step -> old target
//      loaded now, new target at the next period_end.
//   6. Reset mid-fade: rst=1 while FALL with duty=5 -> next cycle state=OFF, duty=0, no
//      duty_load pulse.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM LED core and its fade controller.
package pwm_pkg;

  // Fade sequencer state encoding (also presented on the state output).
  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_RISE = 2'b01,
    ST_ON   = 2'b10,
    ST_FALL = 2'b11
  } fade_state_t;

  // Width of a duty value for a PWM with `scale` steps per period (0..scale-1).
  function automatic int duty_width(input int scale);
    return (scale > 1) ? $clog2(scale) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Push-switch conditioning: 2-FF synchronizer, debounce counter and a
// single-cycle press pulse on an accepted 1->0 transition of the active-low switch.
module sw_debounce #(
  parameter int SYS_CLOCK_FREQ = 50_000_000,
  parameter int DEB_MS         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic press
);

  localparam int DEB_RAW = SYS_CLOCK_FREQ / 1000 * DEB_MS;
  localparam int DEB_CYC = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int CW      = $clog2(DEB_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          settle;

  // The last differing sample of a full window is in flight this cycle.
  assign settle = (cnt == CW'(DEB_CYC - 1));

  // Press is combinational so the FSM reacts on the same edge the level is accepted.
  assign press = (sync2 != level) && settle && !sync2;

  // Synchronize the raw switch and accept a new level after DEB_CYC equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for the PWM LED core: OFF/RISE/ON/FALL fade driven by the
// debounced switch, with duty handed to the PWM core only on a period boundary.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int  SYS_CLOCK_FREQ = 50_000_000,
  parameter int  SCALE          = 256,
  parameter int  DIV            = 1024,
  parameter int  DEB_MS         = 20,
  localparam int W              = duty_width(SCALE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sw_in,
  input  logic         period_end,
  output logic [W-1:0] duty,
  output logic         duty_load,
  output logic [1:0]   state,
  output logic         busy
);

  localparam int           PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TGT_TOP  = W'(SCALE - 1);
  localparam logic [W-1:0] TGT_NEAR = W'(SCALE - 2);
  localparam logic [W-1:0] TGT_ONE  = W'(1);

  fade_state_t   state_q, state_d;
  logic [W-1:0]  target_q, target_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          press;
  logic          fading;
  logic          tick;

  sw_debounce #(
    .SYS_CLOCK_FREQ(SYS_CLOCK_FREQ),
    .DEB_MS        (DEB_MS)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .sw_in(sw_in),
    .press(press)
  );

  assign fading = (state_q == ST_RISE) || (state_q == ST_FALL);
  assign tick   = fading && (presc_q == PW'(DIV - 1));
  assign state  = state_q;

  // Next state, target and prescaler; a press wins and swallows a coincident tick.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    presc_d  = '0;
    if (fading && !tick) presc_d = presc_q + 1'b1;

    if (press) begin
      presc_d = '0;
      case (state_q)
        ST_OFF, ST_FALL: state_d = ST_RISE;
        default:         state_d = ST_FALL;
      endcase
    end else if (tick) begin
      if (state_q == ST_RISE) begin
        // >= also catches a reversal that starts at the top, so target never wraps.
        if (target_q >= TGT_NEAR) begin
          state_d  = ST_ON;
          target_d = TGT_TOP;
        end else begin
          target_d = target_q + 1'b1;
        end
      end else begin
        if (target_q <= TGT_ONE) begin
          state_d  = ST_OFF;
          target_d = '0;
        end else begin
          target_d = target_q - 1'b1;
        end
      end
    end
  end

  // State/prescaler registers and the period-boundary duty handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      target_q  <= '0;
      presc_q   <= '0;
      busy      <= 1'b0;
      duty      <= '0;
      duty_load <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      presc_q   <= presc_d;
      busy      <= (state_d == ST_RISE) || (state_d == ST_FALL);
      duty_load <= 1'b0;
      // target_q is the pre-update value, so a coincident step is loaded next period.
      if (period_end && (target_q != duty)) begin
        duty      <= target_q;
        duty_load <= 1'b1;
      end
    end
  end

endmodule
